// File: rtl/shooting_game_pkg.sv
// Shared constants and state encoding for the shooting-game bullet logic.
package shooting_game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned COORD_W  = 10;

  localparam logic OWNER_P1 = 1'b0;
  localparam logic OWNER_P2 = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fire_req_latch.sv
// Per-player fire request: rising-edge detect on the key level, pending flag
// that survives until the next game tick, cleared while the game is idle.
module fire_req_latch (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  input  logic tick_clr,
  input  logic idle_clr,
  output logic pend
);

  logic fire_prev_q, fire_prev_d;
  logic pend_q, pend_d;
  logic rise;

  always_comb begin
    rise        = fire & ~fire_prev_q;
    fire_prev_d = fire;
    pend_d      = pend_q;
    if (idle_clr) begin
      pend_d = 1'b0;
    end else if (tick_clr) begin
      // An edge landing on the tick cycle is kept for the following tick.
      pend_d = rise;
    end else if (rise) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_prev_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      fire_prev_q <= fire_prev_d;
      pend_q      <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/bullet_arbiter.sv
// Shared bullet-slot scheduler: arbitrates fire requests onto SLOTS slots,
// advances bullets per tick. Optional shot counters via BULLET_ARB_STATS_EN.
module bullet_arbiter
  import shooting_game_pkg::*;
#(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned COOLDOWN = 8,
  parameter int unsigned SPEED    = 4,
  parameter int unsigned SPAWN1_X = 40,
  parameter int unsigned SPAWN2_X = 600
) (
  input  logic                       board_clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       start,
  input  logic                       p1_fire,
  input  logic                       p2_fire,
  input  logic [COORD_W-1:0]         p1_y,
  input  logic [COORD_W-1:0]         p2_y,
  input  logic [SLOTS-1:0]           hit_clear,
  output logic [SLOTS-1:0]           slot_valid,
  output logic [SLOTS-1:0]           slot_owner,
  output logic [SLOTS*COORD_W-1:0]   slot_x,
  output logic [SLOTS*COORD_W-1:0]   slot_y,
  output logic                       p1_grant,
  output logic                       p2_grant
`ifdef BULLET_ARB_STATS_EN
  ,
  output logic [7:0]                 p1_shots,
  output logic [7:0]                 p2_shots
`endif
);

  localparam int unsigned CW   = COORD_W;
  localparam int unsigned CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  arb_state_e        state_q, state_d;
  logic [SLOTS-1:0]  valid_q, valid_d;
  logic [SLOTS-1:0]  owner_q, owner_d;
  logic [CW-1:0]     x_q [SLOTS];
  logic [CW-1:0]     x_d [SLOTS];
  logic [CW-1:0]     y_q [SLOTS];
  logic [CW-1:0]     y_d [SLOTS];
  logic [CD_W-1:0]   cd1_q, cd1_d, cd2_q, cd2_d;
  logic              rr_q, rr_d;
  logic              g1_q, g1_d, g2_q, g2_d;

  logic              idle, run_tick;
  logic              pend1, pend2, elig1, elig2;
  logic [SLOTS-1:0]  first_oh, second_oh, p1_oh, p2_oh;
  logic              found1, found2;
  logic [CW:0]       fwd;

  assign idle     = (state_q == ST_IDLE) || !start;
  assign run_tick = !idle && tick;

  fire_req_latch u_p1_req (
    .clk      (board_clk),
    .rst      (reset),
    .fire     (p1_fire),
    .tick_clr (run_tick),
    .idle_clr (idle),
    .pend     (pend1)
  );

  fire_req_latch u_p2_req (
    .clk      (board_clk),
    .rst      (reset),
    .fire     (p2_fire),
    .tick_clr (run_tick),
    .idle_clr (idle),
    .pend     (pend2)
  );

  // Free slots are those invalid before this tick; slots vacated this cycle
  // are deliberately not eligible.
  always_comb begin
    first_oh  = '0;
    second_oh = '0;
    found1    = 1'b0;
    found2    = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!valid_q[i]) begin
        if (!found1) begin
          first_oh[i] = 1'b1;
          found1      = 1'b1;
        end else if (!found2) begin
          second_oh[i] = 1'b1;
          found2       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    elig1 = pend1 && (cd1_q == '0);
    elig2 = pend2 && (cd2_q == '0);
    p1_oh = '0;
    p2_oh = '0;
    rr_d  = rr_q;
    if (run_tick) begin
      if (elig1 && elig2) begin
        if (found2) begin
          p1_oh = first_oh;
          p2_oh = second_oh;
        end else if (found1) begin
          if (rr_q) p2_oh = first_oh;
          else      p1_oh = first_oh;
          rr_d = ~rr_q;
        end
      end else if (elig1) begin
        p1_oh = first_oh;
      end else if (elig2) begin
        p2_oh = first_oh;
      end
    end
    if (idle) rr_d = 1'b0;
  end

  always_comb begin
    state_d = start ? ST_RUN : ST_IDLE;
    valid_d = valid_q;
    owner_d = owner_q;
    x_d     = x_q;
    y_d     = y_q;
    cd1_d   = cd1_q;
    cd2_d   = cd2_q;
    g1_d    = run_tick && (p1_oh != '0);
    g2_d    = run_tick && (p2_oh != '0);
    fwd     = '0;
    if (idle) begin
      valid_d = '0;
      cd1_d   = '0;
      cd2_d   = '0;
    end else begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        fwd = {1'b0, x_q[i]} + (CW+1)'(SPEED);
        if (hit_clear[i]) begin
          valid_d[i] = 1'b0;
        end else if (run_tick && valid_q[i]) begin
          if (owner_q[i] == OWNER_P1) begin
            if (fwd >= (CW+1)'(SCREEN_W)) valid_d[i] = 1'b0;
            else                          x_d[i]     = fwd[CW-1:0];
          end else begin
            if (x_q[i] < CW'(SPEED)) valid_d[i] = 1'b0;
            else                     x_d[i]     = x_q[i] - CW'(SPEED);
          end
        end
        if (p1_oh[i] || p2_oh[i]) begin
          valid_d[i] = 1'b1;
          owner_d[i] = p2_oh[i] ? OWNER_P2 : OWNER_P1;
          x_d[i]     = p2_oh[i] ? CW'(SPAWN2_X) : CW'(SPAWN1_X);
          y_d[i]     = p2_oh[i] ? p2_y : p1_y;
        end
      end
      if (run_tick) begin
        if (g1_d)              cd1_d = CD_W'(COOLDOWN);
        else if (cd1_q != '0)  cd1_d = cd1_q - CD_W'(1);
        if (g2_d)              cd2_d = CD_W'(COOLDOWN);
        else if (cd2_q != '0)  cd2_d = cd2_q - CD_W'(1);
      end
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      owner_q <= '0;
      cd1_q   <= '0;
      cd2_q   <= '0;
      rr_q    <= 1'b0;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      cd1_q   <= cd1_d;
      cd2_q   <= cd2_d;
      rr_q    <= rr_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_pack
    assign slot_x[gi*CW +: CW] = x_q[gi];
    assign slot_y[gi*CW +: CW] = y_q[gi];
  end

  assign slot_valid = valid_q;
  assign slot_owner = owner_q;
  assign p1_grant   = g1_q;
  assign p2_grant   = g2_q;

`ifdef BULLET_ARB_STATS_EN
  logic [7:0] shots1_q, shots1_d, shots2_q, shots2_d;

  always_comb begin
    shots1_d = shots1_q;
    shots2_d = shots2_q;
    if (idle) begin
      shots1_d = '0;
      shots2_d = '0;
    end else begin
      if (g1_d && (shots1_q != '1)) shots1_d = shots1_q + 8'd1;
      if (g2_d && (shots2_q != '1)) shots2_d = shots2_q + 8'd1;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      shots1_q <= '0;
      shots2_q <= '0;
    end else begin
      shots1_q <= shots1_d;
      shots2_q <= shots2_d;
    end
  end

  assign p1_shots = shots1_q;
  assign p2_shots = shots2_q;
`endif

endmodule

// File: doc/bullet_arbiter.md
# bullet_arbiter

Shared bullet-slot scheduler for the two-player shooting game. Takes per-player fire requests decoded from the keyboard, arbitrates them onto a fixed pool of bullet slots, and enforces a per-player cooldown. Advances every live bullet once per game tick and frees slots on screen exit or on a hit reported by collision logic. Sits between the keyboard decoder and the color generator; the color generator only draws what this block publishes.

## Interface
Parameters:
- SLOTS, 4: number of shared bullet slots (2..8).
- COOLDOWN, 8: ticks a player must wait after a grant before the next grant.
- SPEED, 4: pixels moved per tick.
- SPAWN1_X, 40: spawn x for player-1 bullets, which move toward +x.
- SPAWN2_X, 600: spawn x for player-2 bullets, which move toward -x.

Ports:
- board_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high; clears all state.
- tick  in  1  one-cycle game-frame strobe, synchronous to board_clk.
- start  in  1  level; high = game running.
- p1_fire, p2_fire  in  1 each  fire key levels.
- p1_y, p2_y  in  10 each  current player y, copied into a bullet at spawn.
- hit_clear  in  SLOTS  per-slot free pulse from collision logic.
- slot_valid  out  SLOTS  slot holds a live bullet.
- slot_owner  out  SLOTS  0 = player 1, 1 = player 2.
- slot_x, slot_y  out  SLOTS*10 each  packed positions; slot i is at bits [10i+9:10i].
- p1_grant, p2_grant  out  1 each  one-cycle pulse when a shot is allocated.

## Operation
- States:
  - IDLE is entered on reset or while start=0. All slots invalid, cooldowns 0, pending flags 0, rr_ptr=0.
  - IDLE -> RUN when start=1. RUN -> IDLE in the cycle after start falls.
- Fire request: a rising edge of pN_fire, sampled on board_clk, sets pendN. pendN holds until the next tick.
- Slots freed by hit_clear:
  - hit_clear[i]=1 clears slot_valid[i] on the next edge, in either state.
  - hit_clear takes priority over advance in the same cycle.
- Tick processing, in RUN, all in one cycle:
  1. Advance each valid slot.
     - Owner 1: x+SPEED. Freed if x+SPEED >= 640, computed in 11 bits.
     - Owner 2: x-SPEED. Freed if x < SPEED.
  2. Allocate.
     - Eligibility: pendN=1 and cdN=0.
     - Free slots: slots that were invalid before this tick. Slots freed in step 1 or by hit_clear this cycle cannot be allocated until the next tick.
     - One eligible player: takes the lowest-index free slot.
     - Both eligible, two or more free slots: player 1 takes the lowest free slot, player 2 the next.
     - Both eligible, exactly one free slot: the winner is the player selected by rr_ptr (0 = P1), and rr_ptr toggles.
     - A granted slot gets x=SPAWNn_X, y=pN_y, owner=n.
  3. Cooldown. A granted player's cd loads COOLDOWN. Every other nonzero cd decrements by 1.
  4. Both pend flags clear. Requests that were ineligible or lost arbitration are dropped, not queued.
- A fire edge arriving in the same cycle as tick is held for the next tick.

## Timing
- All outputs are registered.
- Reset values: slot_valid=0, slot_owner=0, slot_x=0, slot_y=0, p1_grant=0, p2_grant=0.
- Allocation latency: a grant or spawn becomes visible on the edge after the tick cycle. The grant pulse lasts exactly 1 cycle.
- Fire edge to visible bullet: the next tick, plus 1 cycle.
- hit_clear to slot_valid low: 1 cycle.
- Asserting reset mid-tick discards that tick entirely.

## Configuration
- BULLET_ARB_STATS_EN defined:
  - Adds outputs p1_shots and p2_shots, 8 bits each.
  - Each counts grants and saturates at 255.
  - Both clear on reset and on entry to IDLE.
- BULLET_ARB_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package shooting_game_pkg:
  - SCREEN_W=640, COORD_W=10.
  - Owner encoding constants OWNER_P1=0, OWNER_P2=1.
  - The arbiter state encoding.
- Sub-module fire_req_latch, instantiated once per player. It contains the edge detector, the pending flag, clear-on-tick, and clear-on-IDLE.

## Test plan
- Spawn: reset, start=1, p1_y=100. Pulse p1_fire, then one tick. Required: slot 0 valid, owner 0, x=40, y=100; p1_grant pulses once.
- Advance and exit: a P1 bullet spawned at 40 with SPEED=4. Required: x=44 after one more tick. The slot is freed on the tick where x+4 >= 640, so x=636 is freed.
- Cooldown: P1 fires on consecutive ticks. Required: the 2nd through 8th requests produce no grant; a request on the 9th tick after the grant is granted.
- Round robin: fill 3 slots, then both players fire on the same tick twice, with slots freed in between. Required: P1 wins first, P2 wins second, and the loser gets no grant.
- Hit priority: assert hit_clear[0] in the same cycle as tick with both players pending and all slots full. Required: slot 0 invalid after the edge and no allocation into slot 0 on that tick.
- Stop mid-game: start falls with 3 live bullets and nonzero cooldowns. Required: next cycle all slot_valid=0; after start rises, an immediate fire is granted.
